// File: rtl/rv32i_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package rv32i_enc_pkg;

  typedef enum logic [2:0] {
    FmtR     = 3'd0,
    FmtI     = 3'd1,
    FmtS     = 3'd2,
    FmtB     = 3'd3,
    FmtU     = 3'd4,
    FmtJ     = 3'd5,
    FmtFence = 3'd6,
    FmtRsvd  = 3'd7
  } enc_fmt_e;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [31:0] word;
    logic        err;
  } enc_word_t;

  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcMiscMem = 7'b0001111;

  localparam logic [31:0] InstNop = 32'h0000_0013;

endpackage

// File: rtl/rv32i_enc_pack.sv
// Combinational field packing and immediate legality check for one request.
// FENCE encoding is enabled by defining RV32I_ENC_FENCE_EN.
module rv32i_enc_pack
  import rv32i_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [31:0] raw;
  logic        bad;
  logic        fits_12;
  logic        fits_13;
  logic        fits_21;

  // A value fits N signed bits when all bits above N-2 match the sign.
  assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    raw = '0;
    bad = 1'b0;
    unique case (enc_fmt_e'(fmt))
      FmtR: raw = {funct7, rs2, rs1, funct3, rd, opcode};
      FmtI: begin
        raw = {imm[11:0], rs1, funct3, rd, opcode};
        bad = ~fits_12;
      end
      FmtS: begin
        raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        bad = ~fits_12;
      end
      FmtB: begin
        raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        bad = ~fits_13 | imm[0];
      end
      FmtU: begin
        raw = {imm[31:12], rd, opcode};
        bad = |imm[11:0];
      end
      FmtJ: begin
        raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        bad = ~fits_21 | imm[0];
      end
      FmtFence: begin
`ifdef RV32I_ENC_FENCE_EN
        raw = {imm[11:0], rs1, funct3, rd, OpcMiscMem};
`else
        bad = 1'b1;
`endif
      end
      FmtRsvd: bad = 1'b1;
    endcase
  end

  assign word    = bad ? InstNop : raw;
  assign illegal = bad;

endmodule

// File: rtl/rv32i_inst_encoder.sv
// RV32I instruction encoder: packs field requests into a 2-entry in-order output buffer.
// Build option: RV32I_ENC_FENCE_EN enables FENCE encoding for enc_fmt=6.
module rv32i_inst_encoder
  import rv32i_enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enc_valid,
  output logic        enc_ready,
  input  logic [2:0]  enc_fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic        inst_err,
  output logic [7:0]  err_count
);

  buf_state_e  state_q, state_d;
  enc_word_t   head_q, head_d;
  enc_word_t   tail_q, tail_d;
  enc_word_t   new_word;
  logic [7:0]  err_count_q, err_count_d;
  logic [31:0] pk_word;
  logic        pk_illegal;
  logic        push;
  logic        pop;

  rv32i_enc_pack u_pack (
    .fmt     (enc_fmt),
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd),
    .imm     (imm),
    .word    (pk_word),
    .illegal (pk_illegal)
  );

  assign enc_ready  = (state_q != StTwo);
  assign inst_valid = (state_q != StEmpty);
  assign inst       = head_q.word;
  assign inst_err   = head_q.err;
  assign err_count  = err_count_q;

  assign push     = enc_valid & enc_ready;
  assign pop      = inst_valid & inst_ready;
  assign new_word = '{word: pk_word, err: pk_illegal};

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          head_d  = new_word;
          state_d = StOne;
        end
      end
      StOne: begin
        if (push && pop) begin
          head_d = new_word;
        end else if (push) begin
          tail_d  = new_word;
          state_d = StTwo;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Only accepted requests count, so a stalled illegal request is counted once.
  always_comb begin
    err_count_d = err_count_q;
    if (push && pk_illegal && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      head_q      <= '0;
      tail_q      <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: doc/rv32i_inst_encoder.md
RV32I_INST_ENCODER -- requirements
Module: rv32i_inst_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port enc_valid, input, 1 bit: field request valid.
REQ-004 SHALL have port enc_ready, output, 1 bit: encoder can accept a request.
REQ-005 SHALL have port enc_fmt, input, 3 bits: format select; R=0, I=1, S=2, B=3, U=4, J=5, FENCE=6; 7 is reserved.
REQ-006 SHALL have ports opcode (input, 7 bits), funct3 (input, 3 bits) and funct7 (input, 7 bits): raw encoding fields.
REQ-007 SHALL have ports rs1, rs2 and rd, input, 5 bits each: register addresses.
REQ-008 SHALL have port imm, input, 32 bits: sign-extended byte offset or value; U-format uses imm[31:12] in place.
REQ-009 SHALL have ports inst_valid (output, 1 bit), inst_ready (input, 1 bit) and inst (output, 32 bits): encoded-word stream.
REQ-010 SHALL have port inst_err, output, 1 bit: the current inst word replaces an illegal request.
REQ-011 SHALL have port err_count, output, 8 bits: saturating count of illegal requests.

Function
REQ-012 SHALL accept a request on a cycle with enc_valid=1 and enc_ready=1, and SHALL present it on inst/inst_valid at the next rising edge (1-cycle latency).
REQ-013 SHALL pop a word on a cycle with inst_valid=1 and inst_ready=1; inst and inst_err SHALL stay stable while inst_valid=1 and inst_ready=0.
REQ-014 SHALL buffer words in a 2-entry in-order store; FSM states EMPTY, ONE, TWO.
REQ-015 FSM transitions SHALL be: push only -> next state; pop only -> previous state; push and pop together in ONE -> ONE.
REQ-016 SHALL drive enc_ready = (state != TWO), combinationally from state only.
REQ-017 SHALL encode each format per the RV32I base ISA bit layouts; opcode is taken from the port for all formats except FENCE.
REQ-018 SHALL treat a request as illegal if any of these holds: I/S imm is outside -2048..2047; B imm is outside -4096..4094 or is odd; J imm is outside -2^20..2^20-2 or is odd; U has imm[11:0] != 0; enc_fmt = 7.
REQ-019 SHALL push an illegal request as 32'h0000_0013 (NOP) with inst_err=1, and SHALL increment err_count, saturating at 8'hFF.
REQ-020 SHALL NOT increment err_count for a request offered while enc_ready=0.

Reset
REQ-021 While rst_n=0, SHALL force state=EMPTY, inst_valid=0, inst=0, inst_err=0 and err_count=0, independent of clk.
REQ-022 SHALL discard buffered words when reset is asserted mid-operation; enc_ready SHALL be 1 on the first edge after rst_n deasserts.

Configuration
REQ-023 When macro RV32I_ENC_FENCE_EN is defined, enc_fmt=6 SHALL encode FENCE as {imm[11:8] fm, imm[7:4] pred, imm[3:0] succ, rs1, funct3, rd, 7'b0001111}.
REQ-024 When RV32I_ENC_FENCE_EN is undefined, enc_fmt=6 SHALL be treated as illegal per REQ-019.

Structure
REQ-025 SHALL place the format enum, opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM) and the NOP constant in shared package rv32i_enc_pkg.
REQ-026 SHALL implement field packing and legality checking as one combinational sub-module rv32i_enc_pack; the buffer FSM and err_count SHALL reside in the top module.

Verification
REQ-027 Bench SHALL cover LUI: fmt=U, opcode 0110111, rd=21, imm=32'hCAD69000 -> inst=32'hCAD69AB7, inst_err=0.
REQ-028 Bench SHALL cover AUIPC: fmt=U, opcode 0010111, rd=10, imm=32'h69CAD000 -> inst=32'h69CAD517.
REQ-029 Bench SHALL cover ADDI: fmt=I, opcode 0010011, rd=1, rs1=0, imm=-1 -> inst=32'hFFF00093.
REQ-030 Bench SHALL cover an illegal B request: fmt=B, imm=3 -> inst=32'h00000013, inst_err=1, err_count=1.
REQ-031 Bench SHALL cover backpressure: inst_ready=0 while 3 requests are offered back-to-back -> enc_ready=0 after 2 accepts; with inst_ready=1, words SHALL be popped in order and the 3rd request accepted.
REQ-032 Bench SHALL cover FENCE with the macro defined: imm=12'h0FF, rd=0, rs1=0 -> inst=32'h0FF0000F; without the macro -> NOP with inst_err=1. Bench SHALL also cover reset asserted in state TWO -> inst_valid=0 immediately.
